// File: rtl/req_arbiter3.sv
// rtl/req_arbiter3.sv - registered 3-requester arbiter with hold, release and timeout; optional ARB_ROUND_ROBIN_EN
module req_arbiter3 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       rel,       // current owner finished; only looked at while granting
    output logic [2:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       gnt_nx;
    logic [1:0]       gnt_id_nx;
    logic             busy_nx;
    logic             timeout_nx;
    logic [1:0]       win_id;
    logic             owner_req;

    function automatic logic [1:0] first_set(input logic [2:0] r);
        if (r[0])      return 2'd0;
        else if (r[1]) return 2'd1;
        else if (r[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    function automatic logic [2:0] id_to_onehot(input logic [1:0] id);
        case (id)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] last_id;
    logic [2:0] rot;
    logic [1:0] base;
    logic [1:0] rot_win;
    logic [2:0] win_sum;

    // rotate the request vector so the search starts just after the last owner
    always_comb begin
        rot  = req;
        base = 2'd0;
        case (last_id)
            2'd0: begin
                rot  = {req[0], req[2], req[1]};
                base = 2'd1;
            end
            2'd1: begin
                rot  = {req[1], req[0], req[2]};
                base = 2'd2;
            end
            default: begin
                rot  = req;
                base = 2'd0;
            end
        endcase
        rot_win = first_set(rot);
        win_sum = {1'b0, rot_win} + {1'b0, base};
        if (rot_win == 2'd3)
            win_id = 2'd3;
        else if (win_sum >= 3'd3)
            win_id = 2'(win_sum - 3'd3);
        else
            win_id = win_sum[1:0];
    end

    // remember who was granted most recently
    always_ff @(posedge clk) begin
        if (rst)
            last_id <= 2'b10;
        else if (state == IDLE && req != 3'b000)
            last_id <= win_id;
    end
`else
    // fixed priority: requester 0 highest
    always_comb begin
        win_id = first_set(req);
    end
`endif

    assign owner_req = |(req & gnt);

    // next state and next registered outputs
    always_comb begin
        state_nx   = IDLE;
        cnt_nx     = '0;
        gnt_nx     = 3'b000;
        gnt_id_nx  = 2'b11;
        busy_nx    = 1'b0;
        timeout_nx = 1'b0;
        case (state)
            IDLE: begin
                if (req != 3'b000) begin
                    state_nx  = GRANT;
                    gnt_nx    = id_to_onehot(win_id);
                    gnt_id_nx = win_id;
                    busy_nx   = 1'b1;
                end
            end
            GRANT: begin
                if (rel || !owner_req) begin
                    state_nx = IDLE;
                end else if (cnt == HOLD_LAST) begin
                    timeout_nx = 1'b1;
                end else begin
                    state_nx  = GRANT;
                    cnt_nx    = cnt + 1'b1;
                    gnt_nx    = gnt;
                    gnt_id_nx = gnt_id;
                    busy_nx   = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // state, hold counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            gnt     <= 3'b000;
            gnt_id  <= 2'b11;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            gnt     <= gnt_nx;
            gnt_id  <= gnt_id_nx;
            busy    <= busy_nx;
            timeout <= timeout_nx;
        end
    end

endmodule

// File: tb/tb_req_arbiter3.sv
// tb/tb_req_arbiter3.sv - scoreboard bench for req_arbiter3 against a cycle-level ownership model
module tb_req_arbiter3;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req = 3'b000;
    logic       rel = 1'b0;
    logic [2:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    typedef struct {
        logic [2:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 1'b0;

    int m_owner = -1;
    int m_held  = 0;
    int m_last  = 2;
    bit m_to    = 1'b0;

    req_arbiter3 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [2:0] r, input int last);
`ifdef ARB_ROUND_ROBIN_EN
        for (int i = 0; i < 3; i++) begin
            int c;
            c = (last + 1 + i) % 3;
            if (r[c]) return c;
        end
`else
        for (int i = 0; i < 3; i++) begin
            if (r[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic model_step(input logic [2:0] r, input logic rl, input logic rs);
        int w;
        m_to = 1'b0;
        if (rs) begin
            m_owner = -1;
            m_held  = 0;
            m_last  = 2;
        end else if (m_owner < 0) begin
            w = pick(r, m_last);
            if (w >= 0) begin
                m_owner = w;
                m_held  = 1;
                m_last  = w;
            end
        end else if (rl || !r[m_owner]) begin
            m_owner = -1;
        end else if (m_held == MAX_HOLD) begin
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_held++;
        end
    endtask

    task automatic cycle(input logic [2:0] r, input logic rl, input logic rs);
        exp_t e;
        @(negedge clk);
        #1;
        req = r;
        rel = rl;
        rst = rs;
        @(posedge clk);
        #1;
        model_step(r, rl, rs);
        e.gnt  = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
        e.id   = (m_owner < 0) ? 2'b11 : 2'(m_owner);
        e.busy = (m_owner >= 0);
        e.to   = m_to;
        exp_q.push_back(e);
    endtask

    // monitor: compare DUT outputs against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (gnt !== e.gnt) begin
                    errors++;
                    $display("FAIL gnt: got %b expected %b at %0t", gnt, e.gnt, $time);
                end
                checks++;
                if (gnt_id !== e.id) begin
                    errors++;
                    $display("FAIL gnt_id: got %b expected %b at %0t", gnt_id, e.id, $time);
                end
                checks++;
                if (busy !== e.busy) begin
                    errors++;
                    $display("FAIL busy: got %b expected %b at %0t", busy, e.busy, $time);
                end
                checks++;
                if (timeout !== e.to) begin
                    errors++;
                    $display("FAIL timeout: got %b expected %b at %0t", timeout, e.to, $time);
                end
            end
        end
    end

    // stimulus: directed scenarios followed by biased random traffic
    initial begin
        // reset with all requesting, then first grant
        cycle(3'b111, 1'b0, 1'b1);
        cycle(3'b111, 1'b0, 1'b1);
        cycle(3'b111, 1'b0, 1'b0);
        cycle(3'b111, 1'b0, 1'b0);
        cycle(3'b000, 1'b1, 1'b0);
        cycle(3'b000, 1'b0, 1'b0);
        // release after three grant cycles, then re-grant
        cycle(3'b110, 1'b0, 1'b0);
        cycle(3'b110, 1'b0, 1'b0);
        cycle(3'b110, 1'b0, 1'b0);
        cycle(3'b110, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(3'b110, 1'b0, 1'b0);
        cycle(3'b000, 1'b0, 1'b0);
        cycle(3'b000, 1'b0, 1'b0);
        // hold limit timeout with release ignored in idle
        for (int i = 0; i < 12; i++) cycle(3'b100, (i == 9), 1'b0);
        cycle(3'b000, 1'b0, 1'b0);
        // owner 2 drops while requester 0 waits
        cycle(3'b100, 1'b0, 1'b0);
        cycle(3'b101, 1'b0, 1'b0);
        cycle(3'b101, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(3'b001, 1'b0, 1'b0);
        cycle(3'b000, 1'b0, 1'b0);
        // reset in grant cycle 4
        for (int i = 0; i < 4; i++) cycle(3'b010, 1'b0, 1'b0);
        cycle(3'b010, 1'b0, 1'b1);
        cycle(3'b000, 1'b0, 1'b0);
        // release on the same edge as the hold limit
        for (int i = 0; i < MAX_HOLD; i++) cycle(3'b001, 1'b0, 1'b0);
        cycle(3'b001, 1'b1, 1'b0);
        cycle(3'b000, 1'b0, 1'b0);
        // everyone requests, release every second grant cycle
        for (int i = 0; i < 18; i++) cycle(3'b111, i[0], 1'b0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] r;
            r[0] = ($urandom_range(7) != 0);
            r[1] = ($urandom_range(7) != 0);
            r[2] = ($urandom_range(7) != 0);
            if ($urandom_range(3) == 0) r = 3'($urandom_range(7));
            cycle(r, ($urandom_range(9) == 0), ($urandom_range(99) == 0));
        end
        stim_done = 1'b1;
    end

    // end of run: drain the scoreboard within a bound
    initial begin
        wait (stim_done);
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // global time limit
    initial begin
        #500000;
        $display("FAIL time_limit: simulation did not finish, expected completion");
        $fatal(1, "time limit");
    end

endmodule
